// File: rtl/cnn_core_mul_pipe.sv
// Pipelined signed multiplier with valid/ready flow control, optional rounded
// arithmetic right shift, and saturate-or-wrap narrowing to the output width.
module cnn_core_mul_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 5,
   parameter int dout_WIDTH = 21,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SATURATE   = 0
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic                         ovf,
   output logic                         ovf_sticky,
   input  logic                         ovf_clr
);

   localparam int PW  = din0_WIDTH + din1_WIDTH;
   localparam int PW1 = PW + 1;
   localparam int EW  = ((PW1 > dout_WIDTH) ? PW1 : dout_WIDTH) + 1;
   localparam int RS  = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [PW:0]   RND  = (ROUND != 0 && SHIFT > 0) ? (PW1'(1) << RS) : '0;
   localparam logic signed [EW-1:0] MAXV = {{(EW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV = {{(EW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

   logic [NUM_STAGE-1:0]         vld;
   logic                         stall;
   logic signed [din0_WIDTH-1:0] a_q;
   logic signed [din1_WIDTH-1:0] b_q;
   logic signed [PW-1:0]         prod;
   logic signed [PW-1:0]         p_last;

   logic signed [PW:0]           sum;
   logic signed [PW:0]           r;
   logic signed [EW-1:0]         r_ext;
   logic                         r_hi;
   logic                         r_lo;
   logic signed [dout_WIDTH-1:0] d_next;

   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld[NUM_STAGE-1];
   assign prod      = PW'(a_q) * PW'(b_q);

   // The whole pipe, valid bits included, freezes while the last stage is blocked.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld <= '0;
         a_q <= '0;
         b_q <= '0;
      end else if (!stall) begin
         vld <= {vld[NUM_STAGE-2:0], in_valid};
         if (in_valid) begin
            a_q <= din0;
            b_q <= din1;
         end
      end
   end

   generate
      if (NUM_STAGE == 2) begin : g_no_preg
         assign p_last = prod;
      end else begin : g_preg
         logic signed [PW-1:0] p_q [NUM_STAGE-2];

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               for (int i = 0; i < NUM_STAGE-2; i++) p_q[i] <= '0;
            end else if (!stall) begin
               p_q[0] <= prod;
               for (int i = 1; i < NUM_STAGE-2; i++) p_q[i] <= p_q[i-1];
            end
         end

         assign p_last = p_q[NUM_STAGE-3];
      end
   endgenerate

   // One guard bit above the product keeps the rounding add from overflowing.
   always_comb begin
      sum    = {p_last[PW-1], p_last} + RND;
      r      = sum >>> SHIFT;
      r_ext  = EW'(r);
      r_hi   = r_ext > MAXV;
      r_lo   = r_ext < MINV;
      d_next = r_ext[dout_WIDTH-1:0];
      if (SATURATE != 0 && r_hi) d_next = {1'b0, {(dout_WIDTH-1){1'b1}}};
      if (SATURATE != 0 && r_lo) d_next = {1'b1, {(dout_WIDTH-1){1'b0}}};
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout <= '0;
         ovf  <= 1'b0;
      end else if (!stall && vld[NUM_STAGE-2]) begin
         dout <= d_next;
         ovf  <= r_hi | r_lo;
      end
   end

   // A set on an overflowing output transfer beats a same-cycle clear.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)                       ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr)                    ovf_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_cnn_core_mul_pipe.sv
// Bench for cnn_core_mul_pipe: five parameter variants share one stimulus stream,
// results are scored in order against an integer reference model or table rows.
module tb_cnn_core_mul_pipe;

   typedef struct {
      int     a;
      int     b;
      longint d_def;
      longint d_r1;
      longint d_r0;
      longint d_sat;
      longint d_wrap;
      bit     o_def;
      bit     o_8;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, in_valid, out_ready, ovf_clr;
   logic signed [15:0] din0;
   logic signed [4:0]  din1;

   logic rdy_def, val_def, ovf_def, stk_def;
   logic rdy_r1, val_r1, ovf_r1, stk_r1;
   logic rdy_r0, val_r0, ovf_r0, stk_r0;
   logic rdy_sat, val_sat, ovf_sat, stk_sat;
   logic rdy_wrap, val_wrap, ovf_wrap, stk_wrap;
   logic signed [20:0] dout_def, dout_r1, dout_r0;
   logic signed [7:0]  dout_sat, dout_wrap;
   logic in_ready;

   int   n_err = 0;
   int   n_chk = 0;
   vec_t q[$];
   vec_t tbl[13];

   always #5 clk = ~clk;
   assign in_ready = rdy_def;

   cnn_core_mul_pipe u_def (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_def),
      .din0(din0), .din1(din1), .out_valid(val_def), .out_ready(out_ready), .dout(dout_def),
      .ovf(ovf_def), .ovf_sticky(stk_def), .ovf_clr(ovf_clr));
   cnn_core_mul_pipe #(.SHIFT(4), .ROUND(1)) u_r1 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid),
      .in_ready(rdy_r1), .din0(din0), .din1(din1), .out_valid(val_r1), .out_ready(out_ready),
      .dout(dout_r1), .ovf(ovf_r1), .ovf_sticky(stk_r1), .ovf_clr(ovf_clr));
   cnn_core_mul_pipe #(.SHIFT(4), .ROUND(0)) u_r0 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid),
      .in_ready(rdy_r0), .din0(din0), .din1(din1), .out_valid(val_r0), .out_ready(out_ready),
      .dout(dout_r0), .ovf(ovf_r0), .ovf_sticky(stk_r0), .ovf_clr(ovf_clr));
   cnn_core_mul_pipe #(.dout_WIDTH(8), .SATURATE(1)) u_sat (.ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy_sat), .din0(din0), .din1(din1), .out_valid(val_sat),
      .out_ready(out_ready), .dout(dout_sat), .ovf(ovf_sat), .ovf_sticky(stk_sat), .ovf_clr(ovf_clr));
   cnn_core_mul_pipe #(.dout_WIDTH(8), .SATURATE(0)) u_wrap (.ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy_wrap), .din0(din0), .din1(din1), .out_valid(val_wrap),
      .out_ready(out_ready), .dout(dout_wrap), .ovf(ovf_wrap), .ovf_sticky(stk_wrap), .ovf_clr(ovf_clr));

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact product, optional half-up bias, floor divide by 2^sh, then clamp or wrap.
   function automatic void fit(input longint p, input int sh, input bit rnd, input int dw,
                               input bit sat, output longint d, output bit o);
      longint r, mx, mn, span;
      span = longint'(1) <<< dw;
      mx   = span / 2 - 1;
      mn   = -(span / 2);
      r    = p;
      if (rnd && sh > 0) r = r + (longint'(1) <<< (sh - 1));
      r = r >>> sh;
      o = (r > mx) || (r < mn);
      if (sat) d = (r > mx) ? mx : ((r < mn) ? mn : r);
      else begin
         d = ((r % span) + span) % span;
         if (d > mx) d = d - span;
      end
   endfunction

   function automatic vec_t model(input int a, input int b);
      vec_t   e;
      bit     o;
      longint p;
      p = longint'(a) * longint'(b);
      e.a = a;
      e.b = b;
      fit(p, 0, 1'b0, 21, 1'b0, e.d_def, e.o_def);
      fit(p, 4, 1'b1, 21, 1'b0, e.d_r1, o);
      fit(p, 4, 1'b0, 21, 1'b0, e.d_r0, o);
      fit(p, 0, 1'b0, 8, 1'b1, e.d_sat, e.o_8);
      fit(p, 0, 1'b0, 8, 1'b0, e.d_wrap, o);
      return e;
   endfunction

   task automatic send_exp(input vec_t e);
      @(negedge clk);
      #1;
      in_valid = 1'b1;
      din0 = 16'(e.a);
      din1 = 5'(e.b);
      #1;
      chk("send_accept", longint'(in_ready), 1);
      if (in_ready) q.push_back(e);
      @(posedge clk);
   endtask

   task automatic send(input int a, input int b);
      send_exp(model(a, b));
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && q.size() != 0; k++) begin
         @(negedge clk);
         #1;
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      chk("drain_empty", longint'(q.size()), 0);
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b0;
         seen = val_def;
      end
      chk(name, longint'(seen), 1);
   endtask

   // Scoreboard: every output transfer must match the oldest outstanding expectation.
   initial begin
      forever begin
         vec_t e;
         @(negedge clk);
         #3;
         if (rst_n && val_def && out_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               e = q.pop_front();
               chk("valid_all", longint'({val_r1, val_r0, val_sat, val_wrap}), 15);
               chk("dout_def", longint'(dout_def), e.d_def);
               chk("dout_r1", longint'(dout_r1), e.d_r1);
               chk("dout_r0", longint'(dout_r0), e.d_r0);
               chk("dout_sat", longint'(dout_sat), e.d_sat);
               chk("dout_wrap", longint'(dout_wrap), e.d_wrap);
               chk("ovf_def", longint'(ovf_def | ovf_r1 | ovf_r0), longint'(e.o_def));
               chk("ovf_sat", longint'(ovf_sat), longint'(e.o_8));
               chk("ovf_wrap", longint'(ovf_wrap), longint'(e.o_8));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] pat;
      longint     held;
      vec_t       bp[6];
      int         idx, sl, lat, ra, rb;
      bit         pend;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; din0 = '0; din1 = '0;
      //           a       b    def      r1      r0      sat   wrap  o21 o8
      tbl[0]  = '{ 32767, -16, -524272, -32767, -32767, -128,  16,  0, 1};
      tbl[1]  = '{ 1,      1,   1,       0,      0,      1,     1,   0, 0};
      tbl[2]  = '{ 2,     -3,  -6,       0,     -1,     -6,    -6,   0, 0};
      tbl[3]  = '{-4,      5,  -20,     -1,     -2,     -20,   -20,  0, 0};
      tbl[4]  = '{ 25,     3,   75,      5,      4,      75,    75,  0, 0};
      tbl[5]  = '{-25,     3,  -75,     -5,     -5,     -75,   -75,  0, 0};
      tbl[6]  = '{ 100,    10,  1000,    63,     62,     127,  -24,  0, 1};
      tbl[7]  = '{-100,    10, -1000,   -62,    -63,    -128,   24,  0, 1};
      tbl[8]  = '{-32768, -16,  524288,  32768,  32768,  127,   0,   0, 1};
      tbl[9]  = '{ 127,    1,   127,     8,      7,      127,   127, 0, 0};
      tbl[10] = '{-128,    1,  -128,    -8,     -8,     -128,  -128, 0, 0};
      tbl[11] = '{ 128,    1,   128,     8,      8,      127,  -128, 0, 1};
      tbl[12] = '{-129,    1,  -129,    -8,     -9,     -128,   127, 0, 1};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", longint'(val_def | val_sat), 0);
      chk("rst_dout", longint'(dout_def), 0);
      chk("rst_ovf", longint'(ovf_def | ovf_sat), 0);
      chk("rst_sticky", longint'(stk_def | stk_sat), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Latency and back-to-back: three pairs from an empty pipe.
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         #1;
         if (c < 3) begin
            in_valid = 1'b1;
            din0 = 16'(tbl[1+c].a);
            din1 = 5'(tbl[1+c].b);
         end else in_valid = 1'b0;
         #1;
         pat[c] = val_def;
         if (c < 3) begin
            chk("b2b_accept", longint'(in_ready), 1);
            q.push_back(tbl[1+c]);
         end
      end
      chk("latency_pattern", longint'(pat), 7'b0111000);
      drain();

      for (int i = 0; i < 13; i++) send_exp(tbl[i]);
      drain();
      repeat (3) @(negedge clk);
      chk("sticky_def", longint'(stk_def | stk_r1 | stk_r0), 0);
      chk("sticky_sat_set", longint'(stk_sat), 1);
      chk("sticky_wrap_set", longint'(stk_wrap), 1);
      @(negedge clk);
      #1 ovf_clr = 1'b1;
      @(negedge clk);
      #1 ovf_clr = 1'b0;
      chk("sticky_cleared", longint'(stk_sat | stk_wrap), 0);

      // Clear coincides with an overflowing output transfer.
      send(-100, 10);
      wait_valid("clr_wait_valid");
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      chk("clr_vs_set", longint'(stk_sat), 1);
      drain();

      // Backpressure: six pairs, four-cycle stall once the first result shows.
      for (int i = 0; i < 6; i++) bp[i] = model($urandom_range(0, 65535) - 32768, $urandom_range(0, 31) - 16);
      idx = 0;
      sl = -1;
      for (int c = 0; c < 60 && !(idx == 6 && sl == 0); c++) begin
         @(negedge clk);
         #1;
         if (sl < 0 && val_def) begin
            sl = 4;
            held = longint'(dout_def);
         end
         out_ready = !(sl > 0);
         if (idx < 6) begin
            in_valid = 1'b1;
            din0 = 16'(bp[idx].a);
            din1 = 5'(bp[idx].b);
         end else in_valid = 1'b0;
         #1;
         if (sl > 0) begin
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_hold", longint'(dout_def), held);
            chk("bp_valid", longint'(val_def), 1);
            sl--;
         end
         if (in_valid && in_ready) begin
            q.push_back(bp[idx]);
            idx++;
         end
      end
      chk("bp_all_sent", longint'(idx), 6);
      drain();

      // out_ready returns in the same cycle a held input is presented.
      send(7, 7);
      wait_valid("resume_wait_valid");
      out_ready = 1'b0;
      in_valid = 1'b1;
      din0 = 16'sd9;
      din1 = -5'sd9;
      #1;
      chk("stall_in_ready", longint'(in_ready), 0);
      held = longint'(dout_def);
      @(negedge clk);
      #1;
      chk("stall_hold", longint'(dout_def), held);
      out_ready = 1'b1;
      #1;
      chk("resume_accept", longint'(in_ready), 1);
      if (in_ready) q.push_back(model(9, -9));
      @(posedge clk);
      drain();

      // Reset with three results in flight.
      send(11, 3);
      send(-7, 2);
      send(300, -5);
      #1;
      chk("inflight_valid", longint'(val_def), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", longint'(val_def | val_sat), 0);
      chk("midrst_dout", longint'(dout_def), 0);
      q.delete();
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      din0 = 16'sd6;
      din1 = -5'sd7;
      #1;
      chk("post_rst_accept", longint'(in_ready), 1);
      if (in_ready) q.push_back(model(6, -7));
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b0;
         if (val_def) lat = k;
      end
      chk("post_rst_latency", longint'(lat), 3);
      drain();
      chk("post_rst_sticky", longint'(stk_sat), 0);

      // Random traffic with random backpressure; the source holds data until accepted.
      pend = 1'b0;
      ra = 0;
      rb = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 9) < 7) begin
            ra = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                             : $urandom_range(0, 65535) - 32768;
            rb = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 15 : -16)
                                             : $urandom_range(0, 31) - 16;
            pend = 1'b1;
         end
         in_valid = pend;
         din0 = 16'(ra);
         din1 = 5'(rb);
         #1;
         chk("rand_in_ready", longint'(in_ready), longint'(!(val_def && !out_ready)));
         if (pend && in_ready) begin
            q.push_back(model(ra, rb));
            pend = 1'b0;
         end
      end
      drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
